// File: rtl/gf_adder_reg.sv
// Registered GF(2^WIDTH) adder (bitwise XOR) with valid handshake and running-accumulate mode.
// Optional zero flag output enabled by defining GF_ADDER_ZERO_FLAG_EN.
module gf_adder_reg #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             in_valid,
  input  logic             acc_mode,
  input  logic             acc_clr,
`ifdef GF_ADDER_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] acc_base, acc_sum;

  // Clear is applied before the accumulate so a same-cycle clear+add starts from ACC_INIT.
  assign acc_base = acc_clr ? ACC_INIT : acc_q;
  assign acc_sum  = acc_base ^ in1 ^ in2;

  // in_valid gates every use of the operands, so X on idle inputs never reaches state.
  always_comb begin
    acc_d = acc_base;
    out_d = out_q;
    vld_d = 1'b0;
    if (in_valid) begin
      vld_d = 1'b1;
      if (acc_mode) begin
        acc_d = acc_sum;
        out_d = acc_sum;
      end else begin
        out_d = in1 ^ in2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= ACC_INIT;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;

`ifdef GF_ADDER_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        zero_q <= 1'b0;
    else if (in_valid) zero_q <= (out_d == '0);
  end
  assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_gf_adder_reg.sv
// Scoreboard bench for gf_adder_reg: expected sums queued at drive time, popped when out_valid appears.
module tb_gf_adder_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in1, in2;
  logic       in_valid, acc_mode, acc_clr;
  logic [7:0] out;
  logic       out_valid;
`ifdef GF_ADDER_ZERO_FLAG_EN
  logic       out_zero;
`endif

  gf_adder_reg #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in1      (in1),
    .in2      (in2),
    .in_valid (in_valid),
    .acc_mode (acc_mode),
    .acc_clr  (acc_clr),
`ifdef GF_ADDER_ZERO_FLAG_EN
    .out_zero (out_zero),
`endif
    .out      (out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic [7:0] m_acc, m_out;
  logic       m_zero;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, update the model, then check one cycle later.
  task automatic step(input logic [7:0] a, input logic [7:0] b,
                      input logic v, input logic m, input logic c);
    logic [7:0] base, r;
    @(negedge clk);
    in1 = a; in2 = b; in_valid = v; acc_mode = m; acc_clr = c;
    base = c ? 8'h00 : m_acc;
    r    = m ? (base ^ a ^ b) : (a ^ b);
    if (v) begin
      q.push_back(r);
      m_out  = r;
      m_zero = (r == 8'h00);
    end
    m_acc = (v && m) ? r : base;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, v);
    if (out_valid) begin
      chk("qlen", q.size(), 1);
      if (q.size() > 0) chk("out_sb", out, q.pop_front());
    end else begin
      chk("out_hold", out, m_out);
    end
`ifdef GF_ADDER_ZERO_FLAG_EN
    chk("out_zero", out_zero, m_zero);
`endif
  endtask

  task automatic idle();
    step('x, 'x, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in1 = '0; in2 = '0; in_valid = 1'b0; acc_mode = 1'b0; acc_clr = 1'b0;
    m_acc = 8'h00; m_out = 8'h00; m_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 8'h00);
    chk("rst_vld", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pairwise vectors
    step(8'h00, 8'h00, 1, 0, 0); chk("p00_00", out, 8'h00);
    step(8'hFF, 8'h00, 1, 0, 0); chk("pFF_00", out, 8'hFF);
    step(8'h00, 8'hFF, 1, 0, 0); chk("p00_FF", out, 8'hFF);
    step(8'hFF, 8'hFF, 1, 0, 0); chk("pFF_FF", out, 8'h00);

    // Single valid pulse, then out must hold with X on idle inputs
    step(8'h3A, 8'hC5, 1, 0, 0); chk("pulse", out, 8'hFF);
    idle(); chk("pulse_hold1", out, 8'hFF);
    idle(); chk("pulse_hold2", out, 8'hFF);

    // Accumulate
    step(8'h01, 8'h02, 1, 1, 0); chk("acc1", out, 8'h03);
    step(8'h04, 8'h08, 1, 1, 0); chk("acc2", out, 8'h0F);
    step(8'h0F, 8'h00, 1, 1, 0); chk("acc3", out, 8'h00);
    step(8'h11, 8'h22, 1, 1, 0); chk("acc4", out, 8'h33);
    step(8'h10, 8'h20, 1, 1, 1); chk("acc_clr_add", out, 8'h30);

    // Pairwise add leaves acc alone; then clear without valid, out unaffected
    step(8'hAA, 8'h0F, 1, 0, 0); chk("pw_mid", out, 8'hA5);
    step(8'h01, 8'h00, 1, 1, 0); chk("acc_kept", out, 8'h31);
    step(8'h00, 8'h00, 0, 0, 1); chk("clr_idle_out", out, 8'h31);
    step(8'h05, 8'h00, 1, 1, 0); chk("acc_after_clr", out, 8'h05);
    step(8'h66, 8'h60, 1, 0, 1); chk("clr_pw", out, 8'h06);
    step(8'h09, 8'h00, 1, 1, 0); chk("acc_after_pwclr", out, 8'h09);

    // Zero flag vectors (also exercise pairwise path in default build)
    step(8'h5A, 8'h5A, 1, 0, 0); chk("z_out", out, 8'h00);
`ifdef GF_ADDER_ZERO_FLAG_EN
    chk("z_flag1", out_zero, 1'b1);
`endif
    step(8'h5A, 8'h00, 1, 0, 0); chk("z_out2", out, 8'h5A);
`ifdef GF_ADDER_ZERO_FLAG_EN
    chk("z_flag0", out_zero, 1'b0);
`endif

    // Back-to-back random pairs
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      step(a, b, 1, 0, 0);
      chk("b2b", out, a ^ b);
    end

    // Mid-run asynchronous reset with a non-zero accumulator
    step(8'h50, 8'h05, 1, 1, 1); chk("pre_rst", out, 8'h55);
    @(negedge clk);
    in_valid = 1'b1; in1 = 8'h12; in2 = 8'h34; acc_mode = 1'b1; acc_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", out, 8'h00);
    chk("arst_vld", out_valid, 1'b0);
    q.delete();
    m_acc = 8'h00; m_out = 8'h00; m_zero = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h00, 8'h00, 1, 1, 0); chk("acc_init", out, 8'h00);

    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
